readout_sequencer: RTL and testbench

//  Sequences row-by-row readout of the pixel array after an exposure completes.

---
 rtl/readout_sequencer_if.sv | 31 +++
 rtl/readout_sequencer.sv | 171 +++++++++++++++++
 tb/tb_readout_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_sequencer_if.sv
// Readout sequencer bus: start/ADC sampling in, row enables/ADC strobe out, pixel stream out (valid/ready).
interface readout_sequencer_if #(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int DATA_W = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                   start;
    logic [COLS*DATA_W-1:0] adc_data;
    logic                   pix_ready;
    logic [ROWS-1:0]        nre;
    logic                   adc;
    logic                   pix_valid;
    logic [DATA_W-1:0]      pix_data;
    logic [RW-1:0]          pix_row;
    logic [CW-1:0]          pix_col;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, adc_data, pix_ready,
        output nre, adc, pix_valid, pix_data, pix_row, pix_col, busy, done
    );

    modport slave (
        output start, adc_data, pix_ready,
        input  nre, adc, pix_valid, pix_data, pix_row, pix_col, busy, done
    );
endinterface

// File: rtl/readout_sequencer.sv
// Row-by-row pixel readout: settle, ADC strobe, capture, then drain one row over valid/ready (held under backpressure).
// First pixel SETTLE_CYCLES+ADC_CYCLES after start; TEST_PATTERN_EN adds test_mode to load {row,col} patterns.
module readout_sequencer #(
    parameter int ROWS          = 2,
    parameter int COLS          = 2,
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int ADC_CYCLES    = 4
) (
    input logic clk,
    input logic reset,
`ifdef TEST_PATTERN_EN
    input logic test_mode,
`endif
    readout_sequencer_if.master bus
);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int WMAX = (SETTLE_CYCLES > ADC_CYCLES) ? SETTLE_CYCLES : ADC_CYCLES;
    localparam int WW   = $clog2(WMAX + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, DRAIN} state_t;

    state_t              state_q, state_nxt;
    logic [RW-1:0]       r_q, r_nxt;
    logic [CW-1:0]       c_q, c_nxt;
    logic [WW-1:0]       w_q, w_nxt;
    logic [DATA_W-1:0]   row_buf_q [COLS];
    logic [DATA_W-1:0]   row_buf_nxt [COLS];
    logic [DATA_W-1:0]   cap [COLS];
    logic [ROWS-1:0]     nre_q, nre_nxt;
    logic                adc_q, adc_nxt;
    logic                pix_valid_q, pix_valid_nxt;
    logic [DATA_W-1:0]   pix_data_q, pix_data_nxt;
    logic [RW-1:0]       pix_row_q, pix_row_nxt;
    logic [CW-1:0]       pix_col_q, pix_col_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                xfer;

    assign xfer = pix_valid_q && bus.pix_ready;

    always_comb begin
        for (int i = 0; i < COLS; i++) begin
            cap[i] = bus.adc_data[i*DATA_W +: DATA_W];
`ifdef TEST_PATTERN_EN
            if (test_mode) begin
                cap[i] = DATA_W'({r_q, CW'(i)});
            end
`endif
        end
    end

    always_comb begin
        state_nxt     = state_q;
        r_nxt         = r_q;
        c_nxt         = c_q;
        w_nxt         = w_q;
        row_buf_nxt   = row_buf_q;
        nre_nxt       = nre_q;
        adc_nxt       = adc_q;
        pix_valid_nxt = pix_valid_q;
        pix_data_nxt  = pix_data_q;
        pix_row_nxt   = pix_row_q;
        pix_col_nxt   = pix_col_q;
        done_nxt      = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q marks the cycle a frame just finished; a start there is dropped
                if (bus.start && !done_q) begin
                    state_nxt = SETTLE;
                    r_nxt     = '0;
                    w_nxt     = '0;
                    nre_nxt   = ~ROWS'(1);
                end
            end
            SETTLE: begin
                if (w_q == WW'(SETTLE_CYCLES - 1)) begin
                    state_nxt = CONVERT;
                    w_nxt     = '0;
                    adc_nxt   = 1'b1;
                end else begin
                    w_nxt = w_q + 1'b1;
                end
            end
            CONVERT: begin
                if (w_q == WW'(ADC_CYCLES - 1)) begin
                    state_nxt     = DRAIN;
                    row_buf_nxt   = cap;
                    adc_nxt       = 1'b0;
                    nre_nxt       = '1;
                    pix_valid_nxt = 1'b1;
                    c_nxt         = '0;
                    pix_data_nxt  = cap[0];
                    pix_row_nxt   = r_q;
                    pix_col_nxt   = '0;
                end else begin
                    w_nxt = w_q + 1'b1;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (c_q != CW'(COLS - 1)) begin
                        c_nxt        = c_q + 1'b1;
                        pix_col_nxt  = c_q + 1'b1;
                        pix_data_nxt = row_buf_q[c_q + 1'b1];
                    end else if (r_q != RW'(ROWS - 1)) begin
                        state_nxt     = SETTLE;
                        pix_valid_nxt = 1'b0;
                        r_nxt         = r_q + 1'b1;
                        w_nxt         = '0;
                        nre_nxt       = ~(ROWS'(1) << (r_q + 1'b1));
                    end else begin
                        state_nxt     = IDLE;
                        pix_valid_nxt = 1'b0;
                        done_nxt      = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            c_q         <= '0;
            w_q         <= '0;
            nre_q       <= '1;
            adc_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_row_q   <= '0;
            pix_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < COLS; i++) begin
                row_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_nxt;
            r_q         <= r_nxt;
            c_q         <= c_nxt;
            w_q         <= w_nxt;
            nre_q       <= nre_nxt;
            adc_q       <= adc_nxt;
            pix_valid_q <= pix_valid_nxt;
            pix_data_q  <= pix_data_nxt;
            pix_row_q   <= pix_row_nxt;
            pix_col_q   <= pix_col_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            for (int i = 0; i < COLS; i++) begin
                row_buf_q[i] <= row_buf_nxt[i];
            end
        end
    end

    assign bus.nre       = nre_q;
    assign bus.adc       = adc_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_row   = pix_row_q;
    assign bus.pix_col   = pix_col_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: stimulus pushes expectations, a negedge monitor compares.
module tb_readout_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    readout_sequencer_if #(.ROWS(2), .COLS(2), .DATA_W(8)) bus ();

`ifdef TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    readout_sequencer #(
        .ROWS(2), .COLS(2), .DATA_W(8), .SETTLE_CYCLES(2), .ADC_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .bus(bus)
    );

    typedef struct packed {
        logic       row;
        logic       col;
        logic [7:0] data;
    } pix_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    pix_t exp_q[$];
    chk_t chk_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int done_seen = 0;
    int done_exp  = 0;
    logic [15:0] row_val [2];

    // ADC model: presents the value of whichever row is currently enabled
    always @(negedge clk) begin
        if (!bus.nre[0])      bus.adc_data = row_val[0];
        else if (!bus.nre[1]) bus.adc_data = row_val[1];
        else                  bus.adc_data = 16'h0000;
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic prev_hold = 1'b0;
    logic prev_last = 1'b0;
    pix_t prev_pix;
    int   nre_run = 0;
    int   adc_run = 0;
    int   adc_first = 0;

    always @(negedge clk) begin
        pix_t e;
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            compare(c.name, c.act, c.exp);
        end
        if (reset) begin
            nre_run   = 0;
            adc_run   = 0;
            prev_hold = 1'b0;
            prev_last = 1'b0;
        end else begin
            compare("done_pulse", 32'(bus.done), 32'(prev_last));
            if (bus.done) begin
                done_seen++;
                compare("busy_at_done", 32'(bus.busy), 32'd0);
            end
            prev_last = bus.pix_valid && bus.pix_ready && bus.pix_row == 1'b1 && bus.pix_col == 1'b1;

            if (prev_hold) begin
                compare("hold_valid", 32'(bus.pix_valid), 32'd1);
                compare("hold_pixel", 32'({bus.pix_row, bus.pix_col, bus.pix_data}), 32'(prev_pix));
            end
            prev_hold = bus.pix_valid && !bus.pix_ready;
            prev_pix  = {bus.pix_row, bus.pix_col, bus.pix_data};

            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got row %0d col %0d data %0h, expected none",
                             bus.pix_row, bus.pix_col, bus.pix_data);
                end else begin
                    e = exp_q.pop_front();
                    compare("pix_row", 32'(bus.pix_row), 32'(e.row));
                    compare("pix_col", 32'(bus.pix_col), 32'(e.col));
                    compare("pix_data", 32'(bus.pix_data), 32'(e.data));
                end
            end

            compare("nre_one_hot_low", 32'($countones(~bus.nre) <= 1), 32'd1);
            if (bus.pix_valid) compare("nre_high_in_drain", 32'(bus.nre), 32'h3);
            if (bus.adc) compare("adc_with_one_row", 32'($countones(~bus.nre)), 32'd1);

            if (bus.nre != 2'b11) begin
                nre_run++;
                if (bus.adc) begin
                    adc_run++;
                    if (adc_run == 1) adc_first = nre_run;
                end
            end else if (nre_run > 0) begin
                compare("nre_low_cycles", 32'(nre_run), 32'd6);
                compare("adc_high_cycles", 32'(adc_run), 32'd4);
                compare("adc_first_cycle", 32'(adc_first), 32'd3);
                nre_run = 0;
                adc_run = 0;
            end
        end
    end

    task automatic note(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_q.push_back('{name, act, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] v0, input logic [15:0] v1);
        row_val[0] = v0;
        row_val[1] = v1;
        exp_q.push_back({1'b0, 1'b0, v0[7:0]});
        exp_q.push_back({1'b0, 1'b1, v0[15:8]});
        exp_q.push_back({1'b1, 1'b0, v1[7:0]});
        exp_q.push_back({1'b1, 1'b1, v1[15:8]});
        done_exp++;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!bus.done && n < lim) begin
            tick();
            n++;
        end
        note("done_reached", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int n;
        bus.start     = 1'b0;
        bus.pix_ready = 1'b1;
        row_val[0]    = 16'h0000;
        row_val[1]    = 16'h0000;
        reset         = 1'b1;
        repeat (3) tick();
        note("rst_nre", 32'(bus.nre), 32'h3);
        note("rst_adc", 32'(bus.adc), 32'd0);
        note("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        note("rst_pix_data", 32'(bus.pix_data), 32'd0);
        note("rst_pix_row", 32'(bus.pix_row), 32'd0);
        note("rst_pix_col", 32'(bus.pix_col), 32'd0);
        note("rst_busy", 32'(bus.busy), 32'd0);
        note("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        tick();

        // reset in the middle of row 0 conversion
        row_val[0] = 16'h5A5A;
        row_val[1] = 16'hA5A5;
        pulse_start();
        n = 0;
        while (!bus.adc && n < 20) begin
            tick();
            n++;
        end
        note("abort_adc_seen", 32'(bus.adc), 32'd1);
        note("abort_nre_convert", 32'(bus.nre), 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        note("abort_nre", 32'(bus.nre), 32'h3);
        note("abort_adc", 32'(bus.adc), 32'd0);
        note("abort_busy", 32'(bus.busy), 32'd0);
        note("abort_pix_valid", 32'(bus.pix_valid), 32'd0);
        repeat (4) tick();

        // nominal frame with first-pixel latency
        push_frame(16'hB2A1, 16'hD4C3);
        pulse_start();
        n = 0;
        while (!bus.pix_valid && n < 50) begin
            tick();
            n++;
        end
        note("first_valid_latency", 32'(n), 32'd6);
        wait_done(100);
        tick();

        // backpressure on pixel (0,1)
        push_frame(16'h2211, 16'h4433);
        pulse_start();
        n = 0;
        while (!(bus.pix_valid && bus.pix_row == 1'b0 && bus.pix_col == 1'b1) && n < 50) begin
            tick();
            n++;
        end
        note("bp_pixel_reached", 32'(bus.pix_col), 32'd1);
        bus.pix_ready = 1'b0;
        repeat (5) tick();
        note("bp_data_held", 32'(bus.pix_data), 32'h22);
        note("bp_nre_row1_high", 32'(bus.nre), 32'h3);
        bus.pix_ready = 1'b1;
        wait_done(100);
        tick();

        // start during drain and on the done cycle is ignored; one cycle later it is taken
        push_frame(16'h6655, 16'h8877);
        pulse_start();
        n = 0;
        while (!(bus.pix_valid && bus.pix_row == 1'b0) && n < 50) begin
            tick();
            n++;
        end
        pulse_start();
        wait_done(100);
        bus.start = 1'b1;
        tick();
        note("start_on_done_ignored", 32'(bus.busy), 32'd0);
        push_frame(16'hAA99, 16'hCCBB);
        tick();
        bus.start = 1'b0;
        note("restart_busy", 32'(bus.busy), 32'd1);
        wait_done(100);
        tick();

`ifdef TEST_PATTERN_EN
        test_mode  = 1'b1;
        row_val[0] = 16'hFFEE;
        row_val[1] = 16'hDDCC;
        exp_q.push_back({1'b0, 1'b0, 8'h00});
        exp_q.push_back({1'b0, 1'b1, 8'h01});
        exp_q.push_back({1'b1, 1'b0, 8'h02});
        exp_q.push_back({1'b1, 1'b1, 8'h03});
        done_exp++;
        pulse_start();
        wait_done(100);
        tick();
        test_mode = 1'b0;
`endif

        repeat (3) tick();
        note("done_count", 32'(done_seen), 32'(done_exp));
        note("queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
